machine_timer: RTL

- Memory-mapped machine timer: free-running 64-bit mtime, mtimecmp compare register, prescaler, simple request/response register port.
- Produces the timer-interrupt-pending level that drives the CSR file's timer interrupt input, which sets or clears mip.MTIP.
- Sits between the core's load/store path (register accesses) and the CSR file (interrupt level).

---
 rtl/machine_timer_if.sv | 28 ++
 rtl/machine_timer.sv | 68 ++++++
 2 files changed

// File: rtl/machine_timer_if.sv
// machine_timer_if: request/response register port between the core load/store path and the machine timer
// Ports (signals):
//   i_req_valid/i_req_write/i_req_addr/i_req_wdata : request from the core (master drives)
//   o_req_ready                                     : timer accepts a request (slave drives)
//   o_resp_valid/o_resp_rdata/o_resp_err            : response from the timer (slave drives)
//   i_resp_ready                                    : core consumes the response (master drives)
interface machine_timer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
);
    logic                  i_req_valid;
    logic                  i_req_write;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [DATA_WIDTH-1:0] i_req_wdata;
    logic                  o_req_ready;
    logic                  o_resp_valid;
    logic                  i_resp_ready;
    logic [DATA_WIDTH-1:0] o_resp_rdata;
    logic                  o_resp_err;
    modport master (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_resp_ready,
        input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err
    );
    modport slave (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_resp_ready,
        output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err
    );
endinterface

// File: rtl/machine_timer.sv
// machine_timer: free-running 64-bit mtime with prescaler, mtimecmp compare and timer-interrupt level
// Ports:
//   clk              : clock
//   arst             : asynchronous active-high reset
//   bus              : register request/response port (0 = mtime, 1 = mtimecmp, 2 = control, 3 = unmapped)
//   o_timer_int_call : registered level, enable & (mtime >= mtimecmp)
module machine_timer #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 2,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 arst,
    machine_timer_if.slave       bus,
    output logic                 o_timer_int_call
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t                 state, state_n;
    logic [DATA_WIDTH-1:0]  mtime, mtimecmp, rdata, rd_val, ctrl_rd;
    logic [PRESC_WIDTH-1:0] div, presc;
    logic                   en, err, irq, accept, tick;
    always_comb begin
        state_n = state == IDLE ? (bus.i_req_valid ? RESP : IDLE) : (bus.i_resp_ready ? IDLE : RESP);
        accept  = state == IDLE && bus.i_req_valid;
        tick    = en && presc == div;
        ctrl_rd = {{(DATA_WIDTH-8-PRESC_WIDTH){1'b0}}, div, 7'b0, en};
        rd_val  = bus.i_req_addr == ADDR_WIDTH'(0) ? mtime :
                  bus.i_req_addr == ADDR_WIDTH'(1) ? mtimecmp :
                  bus.i_req_addr == ADDR_WIDTH'(2) ? ctrl_rd : '0;
    end
    // Register writes come after the counting updates so a same-edge write wins over a tick.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            mtime    <= '0;
            mtimecmp <= '1;
            en       <= 1'b0;
            div      <= '0;
            presc    <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state <= state_n;
            irq   <= en & (mtime >= mtimecmp);
            if (en) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) mtime <= mtime + 1'b1;
            end
            if (accept) begin
                rdata <= bus.i_req_write ? '0 : rd_val;
                err   <= bus.i_req_addr == ADDR_WIDTH'(3);
                if (bus.i_req_write && bus.i_req_addr == ADDR_WIDTH'(0)) mtime <= bus.i_req_wdata;
                if (bus.i_req_write && bus.i_req_addr == ADDR_WIDTH'(1)) mtimecmp <= bus.i_req_wdata;
                if (bus.i_req_write && bus.i_req_addr == ADDR_WIDTH'(2)) begin
                    en    <= bus.i_req_wdata[0];
                    div   <= bus.i_req_wdata[8 +: PRESC_WIDTH];
                    presc <= '0;
                end
            end
        end
    end
    assign bus.o_req_ready  = state == IDLE;
    assign bus.o_resp_valid = state == RESP;
    assign bus.o_resp_rdata = rdata;
    assign bus.o_resp_err   = err;
    assign o_timer_int_call = irq;
endmodule
